// File: rtl/perf_counter_unit.sv
// Saturating cycle/instruction/event counters with a multicycle CPI divider.
// Optional shadow snapshot registers are built when PERF_SNAPSHOT_EN is defined.
module perf_counter_unit #(
    parameter int CNT_W   = 32,
    parameter int NUM_EVT = 4,
    parameter int FRAC_W  = 8,
    parameter int SEL_W   = $clog2(NUM_EVT + 2)
) (
    input  logic                    clk,
    input  logic                    pc_rst,
    input  logic                    clr,
    input  logic                    count_en,
    input  logic                    instr_retire,
    input  logic [NUM_EVT-1:0]      evt_in,
    input  logic [SEL_W-1:0]        rd_sel,
    output logic [CNT_W-1:0]        rd_data,
    output logic [NUM_EVT+1:0]      ovf,
    input  logic                    cpi_start,
    output logic                    cpi_busy,
    output logic                    cpi_valid,
    output logic [CNT_W+FRAC_W-1:0] cpi_q,
    output logic                    cpi_div0,
    input  logic                    snap,
    input  logic                    rd_shadow
);

    localparam int NC = NUM_EVT + 2;
    localparam int QW = CNT_W + FRAC_W;
    localparam int BW = $clog2(QW + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DIV,
        DONE
    } div_state_e;

    logic [CNT_W-1:0] cnt_q [NC];
    logic [CNT_W-1:0] cnt_d [NC];
    logic [NC-1:0]    ovf_q, ovf_d;
    logic [NC-1:0]    inc;

    always_comb begin
        inc   = {evt_in, instr_retire, 1'b1};
        ovf_d = ovf_q;
        for (int i = 0; i < NC; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (clr) begin
            ovf_d = '0;
            for (int i = 0; i < NC; i++) begin
                cnt_d[i] = '0;
            end
        end else if (count_en) begin
            for (int i = 0; i < NC; i++) begin
                if (inc[i]) begin
                    if (&cnt_q[i]) ovf_d[i] = 1'b1;
                    else           cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge pc_rst) begin
        if (pc_rst) begin
            ovf_q <= '0;
            for (int i = 0; i < NC; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ovf_q <= ovf_d;
            for (int i = 0; i < NC; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign ovf = ovf_q;

    // dvd holds C at start, C<<FRAC_W after LOAD, and the quotient as bits shift in
    div_state_e       state_q, state_d;
    logic [QW-1:0]    dvd_q, dvd_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] dsr_q, dsr_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [QW-1:0]    cpi_q_q, cpi_q_d;
    logic             div0_q, div0_d;
    logic             valid_q, valid_d;
    logic [CNT_W:0]   rem_sh, rem_sub;
    logic             qbit;

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        bit_d   = bit_q;
        cpi_q_d = cpi_q_q;
        div0_d  = div0_q;
        valid_d = 1'b0;
        rem_sh  = {rem_q, dvd_q[QW-1]};
        rem_sub = rem_sh - {1'b0, dsr_q};
        qbit    = (rem_sh >= {1'b0, dsr_q});
        unique case (state_q)
            IDLE: begin
                if (cpi_start) begin
                    dvd_d   = QW'(cnt_q[0]);
                    dsr_d   = cnt_q[1];
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (dsr_q == '0) begin
                    dvd_d   = '1;
                    div0_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    dvd_d   = dvd_q << FRAC_W;
                    rem_d   = '0;
                    bit_d   = '0;
                    div0_d  = 1'b0;
                    state_d = DIV;
                end
            end
            DIV: begin
                if (qbit) rem_d = rem_sub[CNT_W-1:0];
                else      rem_d = rem_sh[CNT_W-1:0];
                dvd_d = {dvd_q[QW-2:0], qbit};
                bit_d = bit_q + 1'b1;
                if (bit_q == BW'(QW - 1)) state_d = DONE;
            end
            DONE: begin
                cpi_q_d = dvd_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // clr aborts the divider and drops a coincident start
        if (clr) begin
            state_d = IDLE;
            valid_d = 1'b0;
            div0_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge pc_rst) begin
        if (pc_rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            bit_q   <= '0;
            cpi_q_q <= '0;
            div0_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            bit_q   <= bit_d;
            cpi_q_q <= cpi_q_d;
            div0_q  <= div0_d;
            valid_q <= valid_d;
        end
    end

    assign cpi_busy  = (state_q == LOAD) || (state_q == DIV);
    assign cpi_valid = valid_q;
    assign cpi_q     = cpi_q_q;
    assign cpi_div0  = div0_q;

    logic [CNT_W-1:0] rd_src [NC];

`ifdef PERF_SNAPSHOT_EN
    logic [CNT_W-1:0] shd_q [NC];
    logic [CNT_W-1:0] shd_d [NC];

    always_comb begin
        for (int i = 0; i < NC; i++) begin
            shd_d[i]  = snap ? cnt_d[i] : shd_q[i];
            rd_src[i] = rd_shadow ? shd_q[i] : cnt_q[i];
        end
    end

    always_ff @(posedge clk or posedge pc_rst) begin
        if (pc_rst) begin
            for (int i = 0; i < NC; i++) begin
                shd_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NC; i++) begin
                shd_q[i] <= shd_d[i];
            end
        end
    end
`else
    logic unused_snap;
    assign unused_snap = snap ^ rd_shadow;

    always_comb begin
        for (int i = 0; i < NC; i++) begin
            rd_src[i] = cnt_q[i];
        end
    end
`endif

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NC; i++) begin
            if (rd_sel == SEL_W'(i)) rd_data = rd_src[i];
        end
    end

endmodule

// File: tb/tb_perf_counter_unit.sv
// Scenario bench for perf_counter_unit: counting, CPI divider, clr/reset aborts,
// saturation on an 8-bit instance, and shadow snapshots under PERF_SNAPSHOT_EN.
module tb_perf_counter_unit;

    typedef struct {
        logic [39:0] q;
        logic        div0;
        int          lat;
    } exp_t;

    exp_t sb[$];

    logic        clk = 1'b0;
    logic        pc_rst = 1'b1;
    logic        clr = 1'b0;
    logic        count_en = 1'b0;
    logic        instr_retire = 1'b0;
    logic [3:0]  evt_in = '0;
    logic [2:0]  rd_sel = '0;
    logic        cpi_start = 1'b0;
    logic        snap = 1'b0;
    logic        rd_shadow = 1'b0;
    logic [31:0] rd_data;
    logic [5:0]  ovf;
    logic        cpi_busy, cpi_valid, cpi_div0;
    logic [39:0] cpi_q;

    logic        clr8 = 1'b0;
    logic        en8 = 1'b0;
    logic [3:0]  evt8 = '0;
    logic [2:0]  rd_sel8 = '0;
    logic        zero8 = 1'b0;
    logic [7:0]  rd8;
    logic [5:0]  ovf8;
    logic        busy8, valid8, div08;
    logic [15:0] q8;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int cyc_start = 0;
    logic [39:0] last_q = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    perf_counter_unit dut (
        .clk(clk), .pc_rst(pc_rst), .clr(clr), .count_en(count_en),
        .instr_retire(instr_retire), .evt_in(evt_in), .rd_sel(rd_sel),
        .rd_data(rd_data), .ovf(ovf), .cpi_start(cpi_start),
        .cpi_busy(cpi_busy), .cpi_valid(cpi_valid), .cpi_q(cpi_q),
        .cpi_div0(cpi_div0), .snap(snap), .rd_shadow(rd_shadow)
    );

    perf_counter_unit #(.CNT_W(8)) dut8 (
        .clk(clk), .pc_rst(pc_rst), .clr(clr8), .count_en(en8),
        .instr_retire(zero8), .evt_in(evt8), .rd_sel(rd_sel8),
        .rd_data(rd8), .ovf(ovf8), .cpi_start(zero8),
        .cpi_busy(busy8), .cpi_valid(valid8), .cpi_q(q8),
        .cpi_div0(div08), .snap(zero8), .rd_shadow(zero8)
    );

    task automatic pulse_clr;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic start_cpi(input longint c, input longint i);
        exp_t e;
        if (i == 0) begin
            e.q = '1; e.div0 = 1'b1; e.lat = 2;
        end else begin
            e.q = 40'((c << 8) / i); e.div0 = 1'b0; e.lat = 42;
        end
        sb.push_back(e);
        cpi_start = 1'b1;
        @(negedge clk);
        cpi_start = 1'b0;
        cyc_start = cyc;
    endtask

    task automatic wait_cpi(input string name, input int limit);
        exp_t e;
        int k = 0;
        while (!cpi_valid && k < limit) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (!cpi_valid || sb.size() == 0) begin
            n_err++;
            $display("FAIL %s_timeout: cpi_valid=%0b queued=%0d after %0d cycles",
                     name, cpi_valid, sb.size(), k);
            sb.delete();
        end else begin
            e = sb.pop_front();
            last_q = e.q;
            n_cmp += 3;
            if (cpi_q !== e.q) begin
                n_err++;
                $display("FAIL %s_q: got %0d expected %0d", name, cpi_q, e.q);
            end
            if (cpi_div0 !== e.div0) begin
                n_err++;
                $display("FAIL %s_div0: got %0b expected %0b", name, cpi_div0, e.div0);
            end
            if (cyc - cyc_start != e.lat) begin
                n_err++;
                $display("FAIL %s_lat: got %0d expected %0d", name, cyc - cyc_start, e.lat);
            end
            @(negedge clk);
            n_cmp++;
            if (cpi_valid !== 1'b0) begin
                n_err++;
                $display("FAIL %s_pulse: cpi_valid got %0b expected 0", name, cpi_valid);
            end
        end
    endtask

    task automatic expect_no_valid(input string name, input int n);
        bit seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (cpi_valid) seen = 1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL %s_novalid: cpi_valid seen=%0b expected 0", name, seen);
        end
    endtask

    task automatic test_reset;
        #12;
        for (int s = 0; s < 8; s++) begin
            rd_sel = 3'(s);
            #1;
            n_cmp++;
            if (rd_data !== 32'd0) begin
                n_err++;
                $display("FAIL rst_rd%0d: got %0d expected 0", s, rd_data);
            end
        end
        n_cmp++;
        if ({ovf, cpi_busy, cpi_valid, cpi_div0} !== 9'd0 || cpi_q !== 40'd0) begin
            n_err++;
            $display("FAIL rst_flags: ovf=%0h busy=%0b valid=%0b div0=%0b q=%0d expected 0",
                     ovf, cpi_busy, cpi_valid, cpi_div0, cpi_q);
        end
        @(negedge clk);
        pc_rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cpi;
        pulse_clr();
        for (int i = 0; i < 100; i++) begin
            count_en = 1'b1;
            instr_retire = (i % 2 == 0);
            @(negedge clk);
        end
        count_en = 1'b0;
        instr_retire = 1'b0;
        rd_sel = 3'd0;
        #1;
        n_cmp++;
        if (rd_data !== 32'd100) begin
            n_err++;
            $display("FAIL cpi_cycles: got %0d expected 100", rd_data);
        end
        rd_sel = 3'd1;
        #1;
        n_cmp++;
        if (rd_data !== 32'd50) begin
            n_err++;
            $display("FAIL cpi_instrs: got %0d expected 50", rd_data);
        end
        start_cpi(100, 50);
        wait_cpi("cpi_2p0", 60);
    endtask

    task automatic test_div0;
        pulse_clr();
        start_cpi(0, 0);
        wait_cpi("div0", 10);
    endtask

    task automatic test_back_to_back;
        pulse_clr();
        for (int i = 0; i < 30; i++) begin
            count_en = 1'b1;
            instr_retire = (i % 3 == 0);
            @(negedge clk);
        end
        count_en = 1'b0;
        instr_retire = 1'b0;
        start_cpi(30, 10);
        for (int i = 0; i < 5; i++) begin
            count_en = 1'b1;
            instr_retire = 1'b1;
            cpi_start = (i == 2);
            @(negedge clk);
        end
        count_en = 1'b0;
        instr_retire = 1'b0;
        cpi_start = 1'b0;
        wait_cpi("b2b", 60);
        expect_no_valid("b2b_ignored", 50);
        rd_sel = 3'd0;
        #1;
        n_cmp++;
        if (rd_data !== 32'd35) begin
            n_err++;
            $display("FAIL b2b_cycles: got %0d expected 35", rd_data);
        end
        rd_sel = 3'd1;
        #1;
        n_cmp++;
        if (rd_data !== 32'd15) begin
            n_err++;
            $display("FAIL b2b_instrs: got %0d expected 15", rd_data);
        end
    endtask

    task automatic test_clr_abort;
        pulse_clr();
        for (int i = 0; i < 40; i++) begin
            count_en = 1'b1;
            instr_retire = 1'b1;
            @(negedge clk);
        end
        count_en = 1'b0;
        instr_retire = 1'b0;
        cpi_start = 1'b1;
        @(negedge clk);
        cpi_start = 1'b0;
        repeat (11) @(negedge clk);
        n_cmp++;
        if (cpi_busy !== 1'b1) begin
            n_err++;
            $display("FAIL abort_busy_before: got %0b expected 1", cpi_busy);
        end
        clr = 1'b1;
        cpi_start = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        cpi_start = 1'b0;
        n_cmp++;
        if (cpi_busy !== 1'b0 || cpi_valid !== 1'b0) begin
            n_err++;
            $display("FAIL abort_busy_after: busy=%0b valid=%0b expected 0 0",
                     cpi_busy, cpi_valid);
        end
        expect_no_valid("abort", 60);
        n_cmp++;
        if (cpi_q !== last_q || cpi_div0 !== 1'b0) begin
            n_err++;
            $display("FAIL abort_q: q=%0d div0=%0b expected %0d 0", cpi_q, cpi_div0, last_q);
        end
        rd_sel = 3'd0;
        #1;
        n_cmp++;
        if (rd_data !== 32'd0) begin
            n_err++;
            $display("FAIL abort_cleared: got %0d expected 0", rd_data);
        end
    endtask

    task automatic test_reset_mid;
        pulse_clr();
        for (int i = 0; i < 57; i++) begin
            count_en = 1'b1;
            instr_retire = 1'b1;
            @(negedge clk);
        end
        count_en = 1'b0;
        instr_retire = 1'b0;
        rd_sel = 3'd0;
        #1;
        n_cmp++;
        if (rd_data !== 32'd57) begin
            n_err++;
            $display("FAIL mid_cycles: got %0d expected 57", rd_data);
        end
        cpi_start = 1'b1;
        @(negedge clk);
        cpi_start = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        pc_rst = 1'b1;
        #1;
        n_cmp++;
        if (rd_data !== 32'd0 || ovf !== 6'd0 || cpi_busy !== 1'b0 ||
            cpi_valid !== 1'b0 || cpi_q !== 40'd0) begin
            n_err++;
            $display("FAIL mid_rst: rd=%0d ovf=%0h busy=%0b valid=%0b q=%0d expected all 0",
                     rd_data, ovf, cpi_busy, cpi_valid, cpi_q);
        end
        rd_sel = 3'd1;
        #1;
        n_cmp++;
        if (rd_data !== 32'd0) begin
            n_err++;
            $display("FAIL mid_rst_instrs: got %0d expected 0", rd_data);
        end
        @(negedge clk);
        pc_rst = 1'b0;
        expect_no_valid("mid_rst", 60);
    endtask

    task automatic test_events;
        logic [31:0] m [6];
        logic [3:0]  ev;
        logic        ir, en;
        pulse_clr();
        for (int k = 0; k < 6; k++) m[k] = '0;
        for (int i = 0; i < 24; i++) begin
            ev = 4'($urandom_range(0, 15));
            ir = 1'($urandom_range(0, 1));
            en = (i % 5 != 4);
            evt_in = ev;
            instr_retire = ir;
            count_en = en;
            if (en) begin
                m[0]++;
                if (ir) m[1]++;
                for (int k = 0; k < 4; k++) if (ev[k]) m[2+k]++;
            end
            @(negedge clk);
        end
        count_en = 1'b0;
        evt_in = '0;
        instr_retire = 1'b0;
        for (int s = 0; s < 8; s++) begin
            rd_sel = 3'(s);
            #1;
            n_cmp++;
            if (rd_data !== ((s < 6) ? m[s] : 32'd0)) begin
                n_err++;
                $display("FAIL evt_rd%0d: got %0d expected %0d", s, rd_data,
                         (s < 6) ? m[s] : 32'd0);
            end
        end
        n_cmp++;
        if (ovf !== 6'd0) begin
            n_err++;
            $display("FAIL evt_ovf: got %0h expected 0", ovf);
        end
    endtask

    task automatic test_saturation;
        clr8 = 1'b1;
        @(negedge clk);
        clr8 = 1'b0;
        for (int i = 0; i < 300; i++) begin
            en8 = 1'b1;
            evt8 = 4'b0001;
            @(negedge clk);
        end
        en8 = 1'b0;
        evt8 = '0;
        rd_sel8 = 3'd2;
        #1;
        n_cmp++;
        if (rd8 !== 8'd255) begin
            n_err++;
            $display("FAIL sat_evt0: got %0d expected 255", rd8);
        end
        rd_sel8 = 3'd0;
        #1;
        n_cmp++;
        if (rd8 !== 8'd255 || ovf8 !== 6'b000101) begin
            n_err++;
            $display("FAIL sat_ovf: cycles=%0d ovf=%b expected 255 000101", rd8, ovf8);
        end
        clr8 = 1'b1;
        @(negedge clk);
        clr8 = 1'b0;
        rd_sel8 = 3'd2;
        #1;
        n_cmp++;
        if (rd8 !== 8'd0 || ovf8 !== 6'd0) begin
            n_err++;
            $display("FAIL sat_clr: evt0=%0d ovf=%b expected 0 000000", rd8, ovf8);
        end
    endtask

`ifdef PERF_SNAPSHOT_EN
    task automatic test_snapshot;
        pulse_clr();
        count_en = 1'b1;
        repeat (20) @(negedge clk);
        snap = 1'b1;
        @(negedge clk);
        snap = 1'b0;
        repeat (30) @(negedge clk);
        count_en = 1'b0;
        rd_sel = 3'd0;
        rd_shadow = 1'b1;
        #1;
        n_cmp++;
        if (rd_data !== 32'd21) begin
            n_err++;
            $display("FAIL snap_shadow: got %0d expected 21", rd_data);
        end
        rd_shadow = 1'b0;
        #1;
        n_cmp++;
        if (rd_data !== 32'd51) begin
            n_err++;
            $display("FAIL snap_live: got %0d expected 51", rd_data);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_cpi();
        test_div0();
        test_back_to_back();
        test_clr_abort();
        test_reset_mid();
        test_events();
        test_saturation();
`ifdef PERF_SNAPSHOT_EN
        test_snapshot();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/perf_counter_unit.md
Name: perf_counter_unit

Overview:
- Synthesizable performance-monitoring block that sits beside the CPU core.
- Counts elapsed cycles, retired instructions and NUM_EVT generic event channels (stalls, flushes, misses).
- A multicycle divider computes fixed-point CPI on request.
- Replaces testbench-only cycle/instruction/CPI bookkeeping with parametrised, saturating, readable hardware counters.

Parameters:
- CNT_W, 32: width of every counter.
- NUM_EVT, 4: number of generic event channels (1..16).
- FRAC_W, 8: fractional bits of the CPI result.
- SEL_W, $clog2(NUM_EVT+2): readout select width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- pc_rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear of counters, flags and divider.
- count_en  in  1  counting enabled when high; counters hold when low.
- instr_retire  in  1  one instruction retired this cycle.
- evt_in  in  NUM_EVT  per-channel event strobe, one count per cycle high.
- rd_sel  in  SEL_W  readout select.
- rd_data  out  CNT_W  selected counter value.
- ovf  out  NUM_EVT+2  sticky saturation flags: bit0 cycles, bit1 instrs, bit2+k event k.
- cpi_start  in  1  pulse that requests a CPI computation.
- cpi_busy  out  1  divider running.
- cpi_valid  out  1  one-cycle pulse when cpi_q is updated.
- cpi_q  out  CNT_W+FRAC_W  CPI in unsigned Q(CNT_W).FRAC_W format.
- cpi_div0  out  1  last computation had zero instructions.
- snap  in  1  shadow capture strobe (used only with PERF_SNAPSHOT_EN).
- rd_shadow  in  1  read shadow copy instead of live counters (used only with PERF_SNAPSHOT_EN).

Behaviour:
- pc_rst asserted: all counters, ovf, cpi_q, cpi_div0, cpi_busy and cpi_valid go to 0 immediately, without waiting for clk. Divider state returns to IDLE.
- Counting happens when count_en=1 and clr=0:
  - cycle counter +1 every clk.
  - instruction counter +1 when instr_retire=1.
  - event counter k +1 when evt_in[k]=1.
- Counters saturate at all-ones and never wrap. An increment attempted while a counter is at all-ones sets its ovf bit, which stays set until clr or pc_rst.
- clr has priority over counting. Next edge: all counters = 0, ovf = 0, cpi_div0 = 0, divider aborts to IDLE with cpi_busy = 0 and no cpi_valid pulse. cpi_q keeps its last value.
- Readout is combinational:
  - rd_sel 0: cycles.
  - rd_sel 1: instructions.
  - rd_sel 2+k: event k.
  - any other rd_sel value: 0.
- Divider FSM has states IDLE, LOAD, DIV, DONE.
  - IDLE: cpi_start=1 captures snapshots C (cycles) and I (instrs) at edge N, then go to LOAD.
  - LOAD (cycle N+1): cpi_busy=1.
    - If I=0: cpi_q = all-ones, cpi_div0 = 1, go to DONE.
    - Otherwise: dividend = C<<FRAC_W, remainder = 0, cpi_div0 = 0, go to DIV.
  - DIV: restoring shift-subtract, one quotient bit per cycle, CNT_W+FRAC_W cycles, then DONE.
  - DONE: cpi_q updated, cpi_valid=1 for exactly one cycle, cpi_busy=0, return to IDLE.
  - Latency from start edge to cpi_valid: 2+CNT_W+FRAC_W cycles, or 2 cycles for the div0 case.
  - cpi_start while not IDLE is ignored.
- Counters keep running during division; the result reflects the values snapshotted at start.
- Simultaneous cpi_start and clr: clr wins and the start is dropped.

Optional Feature:
- Macro: PERF_SNAPSHOT_EN.
- Defined:
  - Adds one shadow register per counter (NUM_EVT+2 of them).
  - snap=1 copies all live counters atomically at the edge, including the value incremented in that same cycle.
  - rd_shadow=1 steers rd_data from the shadow copies.
  - Shadows are cleared by pc_rst but not by clr.
- Undefined: snap and rd_shadow are ignored, rd_data always shows live counters, and no shadow flops are synthesized.

Test Plan:
- pc_rst pulse mid-count, with cycles=57 and a DIV in progress -> all counters, ovf and cpi_busy read 0 before the next clk edge; no cpi_valid follows.
- 100 cycles with count_en=1 and instr_retire toggling every cycle (50 retirements), then cpi_start -> rd_sel0=100, rd_sel1=50; cpi_valid exactly 42 cycles after the start edge with cpi_q=512 (2.0), cpi_div0=0.
- cpi_start with 0 instructions retired -> cpi_valid 2 cycles after start, cpi_q=all-ones, cpi_div0=1.
- CNT_W=8, evt_in[0] held high for 300 cycles -> rd_sel2=255, ovf[2]=1; clr -> rd_sel2=0, ovf=0.
- clr asserted at DIV cycle 10 -> cpi_busy low next cycle, no cpi_valid, cpi_q unchanged; a cpi_start in the same cycle as clr is ignored.
- PERF_SNAPSHOT_EN: snap at cycles=20, run 30 more cycles, rd_shadow=1 with rd_sel=0 -> reads 21 (the count after the edge); rd_shadow=0 -> reads 51.
